c3aibadapt_avmm_ssr_sched: RTL and testbench
============================================

// Module: c3aibadapt_avmm_ssr_sched
//
// PURPOSE
// - Frame scheduler for the AVMM hard-reset serial status register (SSR) path in the tx osc clock domain.
// - Generates periodic SSR load pulses and shift enables, and counts completed frames.
// - Confirms the osc transfer-enable handshake: asserts confirmed only after the fabric echo of
//   transfer_en has matched the local request for CONFIRM_FRAMES consecutive frames.
// - Sits between the hard-reset state machine and the async capture/update cells of the AVMM SSR.
//
// PARAMETERS
// - SSR_LEN        default 8   SSR bits per frame (shift cycles); legal range 1..255.
// - GAP_CYC        default 4   idle cycles between frames, including the frame_done cycle; legal range 1..255.
// - CONFIRM_FRAMES default 2   consecutive matching frames required for confirm; legal range 1..15.
//
// PORTS
// - avmm_clock_hrdrst_tx_osc_clk            in   1   clock
// - avmm_reset_hrdrst_tx_osc_clk_rst        in   1   synchronous, active-high reset
// - ssr_enable                              in   1   run continuous frames
// - ssr_flush_req                           in   1   request one frame as early as possible (single-cycle pulse)
// - avmm_hrdrst_hssi_osc_transfer_en        in   1   transfer-enable request from reset SM
// - sr_fabric_osc_transfer_en               in   1   fabric echo, already synchronised
// - avmm_async_hssi_fabric_ssr_load         out  1   SSR load/unload pulse
// - ssr_shift_en                            out  1   SSR shift enable
// - ssr_frame_done                          out  1   one-cycle pulse after the last shift cycle
// - transfer_en_confirmed                   out  1   handshake confirmed to reset SM
// - ssr_frame_cnt                           out  16  completed frames, wraps at 0xFFFF -> 0
//
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; bit/gap/confirm counters and flush_pend cleared.
//   Reset asserted mid-frame aborts the frame on the next edge.
// - All outputs are registered, Moore decode: load=1 iff LOAD; shift_en=1 iff SHIFT.
// - IDLE:  ssr_enable | ssr_flush_req -> LOAD.
// - LOAD:  1 cycle -> SHIFT; bit_cnt=0.
// - SHIFT: exactly SSR_LEN cycles; at bit_cnt==SSR_LEN-1 -> GAP, gap_cnt=0, ssr_frame_done=1 during first GAP cycle.
// - GAP:   lasts GAP_CYC cycles.
//   - flush_pend set in first GAP cycle -> LOAD next (gap cut short), flush_pend cleared.
//   - Otherwise at gap_cnt==GAP_CYC-1: ssr_enable ? LOAD : IDLE.
// - Frame period with ssr_enable held = 1 + SSR_LEN + GAP_CYC cycles.
// - ssr_flush_req during LOAD/SHIFT/GAP sets flush_pend (multiple requests merge into one frame).
//   ssr_flush_req in IDLE starts the frame directly, with no pend.
//   ssr_flush_req in the last GAP cycle with enable high is absorbed.
// - ssr_enable deasserted mid-frame: current frame and its gap complete, then IDLE. A frame is never truncated.
// - ssr_frame_cnt increments in the ssr_frame_done cycle.
// - Confirm logic, evaluated in the frame_done cycle:
//   - match = req & echo.
//   - match: conf_cnt saturating increment, cap CONFIRM_FRAMES.
//   - mismatch: conf_cnt=0.
//   - transfer_en_confirmed = (conf_cnt==CONFIRM_FRAMES), registered.
// - req low at any cycle: conf_cnt=0 and confirmed=0 on the next edge, without waiting for a frame.
// - Simultaneous req-fall and frame_done: clear wins.
//
// STRUCTURE
// - Shared package c3aibadapt_avmm_pkg: state encoding constants (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, GAP=2'd3).
// - Single module; no sub-module. bit_cnt and gap_cnt share one 8-bit counter.
//
// TESTING  (SSR_LEN=8, GAP_CYC=4, CONFIRM_FRAMES=2)
// - Continuous run: release reset, raise enable.
//   -> load at cycle 1; shift_en cycles 2-9; frame_done cycle 10; next load cycle 14 (period 13); frame_cnt=3 after 3 frames.
// - Flush from IDLE: enable=0, 1-cycle flush.
//   -> exactly one frame (1 load, 8 shifts, 1 done), then IDLE.
// - Flush while shifting, enable=1: flush at shift cycle 3.
//   -> next load in the cycle after frame_done (gap = 1 cycle).
// - Confirm: req=1, echo=1.
//   -> confirmed rises the cycle after the 2nd frame_done.
//   -> echo drops before the 3rd frame: confirmed falls after the 3rd frame_done.
//   -> req drops: confirmed falls 1 cycle later.
// - Disable mid-frame: enable falls at shift cycle 5.
//   -> remaining shifts and the 4-cycle gap complete, then IDLE, no further load.
// - Reset mid-SHIFT: all outputs 0 on the next cycle; frame_cnt=0; confirmed=0.

Source files
------------

// File: rtl/c3aibadapt_avmm_pkg.sv
// Shared definitions for the AVMM hard-reset SSR path: scheduler state encoding
// and counter widths.
package c3aibadapt_avmm_pkg;

    typedef enum logic [1:0] {
        SSR_IDLE  = 2'd0,
        SSR_LOAD  = 2'd1,
        SSR_SHIFT = 2'd2,
        SSR_GAP   = 2'd3
    } ssr_state_e;

    // bit_cnt and gap_cnt share one counter of this width
    localparam int SSR_CNT_W  = 8;
    localparam int CONF_CNT_W = 4;
    localparam int FRAME_CNT_W = 16;

endpackage : c3aibadapt_avmm_pkg

// File: rtl/c3aibadapt_avmm_ssr_sched.sv
// SSR frame scheduler in the tx osc clock domain: periodic load/shift framing,
// frame counting and confirmation of the osc transfer-enable handshake.
//
// Handshake: transfer_en_confirmed rises only after the fabric echo matched the
// request in CONFIRM_FRAMES consecutive frame_done cycles; a low request clears
// it on the next edge regardless of framing.
module c3aibadapt_avmm_ssr_sched
    import c3aibadapt_avmm_pkg::*;
#(
    parameter int SSR_LEN        = 8,
    parameter int GAP_CYC        = 4,
    parameter int CONFIRM_FRAMES = 2
) (
    input  logic                   avmm_clock_hrdrst_tx_osc_clk,
    input  logic                   avmm_reset_hrdrst_tx_osc_clk_rst,
    input  logic                   ssr_enable,
    input  logic                   ssr_flush_req,
    input  logic                   avmm_hrdrst_hssi_osc_transfer_en,
    input  logic                   sr_fabric_osc_transfer_en,
    output logic                   avmm_async_hssi_fabric_ssr_load,
    output logic                   ssr_shift_en,
    output logic                   ssr_frame_done,
    output logic                   transfer_en_confirmed,
    output logic [FRAME_CNT_W-1:0] ssr_frame_cnt
);

    localparam logic [SSR_CNT_W-1:0]  LAST_BIT = SSR_CNT_W'(SSR_LEN - 1);
    localparam logic [SSR_CNT_W-1:0]  LAST_GAP = SSR_CNT_W'(GAP_CYC - 1);
    localparam logic [CONF_CNT_W-1:0] CONF_MAX = CONF_CNT_W'(CONFIRM_FRAMES);

    logic clk;
    logic rst;
    assign clk = avmm_clock_hrdrst_tx_osc_clk;
    assign rst = avmm_reset_hrdrst_tx_osc_clk_rst;

    ssr_state_e             state_q, state_d;
    logic [SSR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   load_d, shift_d, done_d;
    logic [CONF_CNT_W-1:0]  conf_q, conf_d;
    logic                   confirmed_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SSR_IDLE;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        unique case (state_q)
            SSR_IDLE: begin
                cnt_d = '0;
                if (ssr_enable || ssr_flush_req) begin
                    state_d = SSR_LOAD;
                end
            end
            SSR_LOAD: begin
                cnt_d   = '0;
                state_d = SSR_SHIFT;
                if (ssr_flush_req) begin
                    flush_pend_d = 1'b1;
                end
            end
            SSR_SHIFT: begin
                if (ssr_flush_req) begin
                    flush_pend_d = 1'b1;
                end
                if (cnt_q == LAST_BIT) begin
                    state_d = SSR_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SSR_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0 && flush_pend_q) begin
                    // pending flush cuts the gap; a request arriving now merges into it
                    state_d      = SSR_LOAD;
                    flush_pend_d = 1'b0;
                end else if (cnt_q == LAST_GAP) begin
                    flush_pend_d = 1'b0;
                    if (ssr_enable || flush_pend_q || ssr_flush_req) begin
                        state_d = SSR_LOAD;
                    end else begin
                        state_d = SSR_IDLE;
                    end
                end else if (ssr_flush_req) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: begin
                state_d      = SSR_IDLE;
                cnt_d        = '0;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with state_q.
    always_comb begin
        load_d  = (state_d == SSR_LOAD);
        shift_d = (state_d == SSR_SHIFT);
        done_d  = (state_q == SSR_SHIFT) && (cnt_q == LAST_BIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avmm_async_hssi_fabric_ssr_load <= 1'b0;
            ssr_shift_en                    <= 1'b0;
            ssr_frame_done                  <= 1'b0;
        end else begin
            avmm_async_hssi_fabric_ssr_load <= load_d;
            ssr_shift_en                    <= shift_d;
            ssr_frame_done                  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter and transfer-enable confirmation
    // ------------------------------------------------------------------
    always_comb begin
        frame_cnt_d = ssr_frame_cnt;
        if (ssr_frame_done) begin
            frame_cnt_d = ssr_frame_cnt + 1'b1;
        end
    end

    always_comb begin
        conf_d      = conf_q;
        confirmed_d = transfer_en_confirmed;
        if (!avmm_hrdrst_hssi_osc_transfer_en) begin
            // request fall beats a coincident frame_done
            conf_d      = '0;
            confirmed_d = 1'b0;
        end else if (ssr_frame_done) begin
            if (avmm_hrdrst_hssi_osc_transfer_en && sr_fabric_osc_transfer_en) begin
                conf_d = (conf_q == CONF_MAX) ? CONF_MAX : conf_q + 1'b1;
            end else begin
                conf_d = '0;
            end
            confirmed_d = (conf_d == CONF_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ssr_frame_cnt         <= '0;
            conf_q                <= '0;
            transfer_en_confirmed <= 1'b0;
        end else begin
            ssr_frame_cnt         <= frame_cnt_d;
            conf_q                <= conf_d;
            transfer_en_confirmed <= confirmed_d;
        end
    end

endmodule : c3aibadapt_avmm_ssr_sched

// File: tb/tb_c3aibadapt_avmm_ssr_sched.sv
// Directed bench for the SSR frame scheduler (SSR_LEN=8, GAP_CYC=4, CONFIRM_FRAMES=2).
module tb_c3aibadapt_avmm_ssr_sched;

    logic        clk;
    logic        rst;
    logic        ssr_enable;
    logic        ssr_flush_req;
    logic        req;
    logic        echo;
    logic        load;
    logic        shift_en;
    logic        frame_done;
    logic        confirmed;
    logic [15:0] frame_cnt;

    int n_checks;
    int n_fail;

    c3aibadapt_avmm_ssr_sched #(
        .SSR_LEN        (8),
        .GAP_CYC        (4),
        .CONFIRM_FRAMES (2)
    ) dut (
        .avmm_clock_hrdrst_tx_osc_clk     (clk),
        .avmm_reset_hrdrst_tx_osc_clk_rst (rst),
        .ssr_enable                       (ssr_enable),
        .ssr_flush_req                    (ssr_flush_req),
        .avmm_hrdrst_hssi_osc_transfer_en (req),
        .sr_fabric_osc_transfer_en        (echo),
        .avmm_async_hssi_fabric_ssr_load  (load),
        .ssr_shift_en                     (shift_en),
        .ssr_frame_done                   (frame_done),
        .transfer_en_confirmed            (confirmed),
        .ssr_frame_cnt                    (frame_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n clock edges; sample and drive 1 time unit after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int c, input bit e_load,
                             input bit e_shift, input bit e_done);
        chk($sformatf("%s_load_c%0d", tag, c), {15'd0, load}, {15'd0, e_load});
        chk($sformatf("%s_shift_c%0d", tag, c), {15'd0, shift_en}, {15'd0, e_shift});
        chk($sformatf("%s_done_c%0d", tag, c), {15'd0, frame_done}, {15'd0, e_done});
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        ssr_enable    = 1'b0;
        ssr_flush_req = 1'b0;
        req           = 1'b0;
        echo          = 1'b0;

        // reset state
        step(3);
        chk("rst_load", {15'd0, load}, 16'd0);
        chk("rst_shift", {15'd0, shift_en}, 16'd0);
        chk("rst_done", {15'd0, frame_done}, 16'd0);
        chk("rst_conf", {15'd0, confirmed}, 16'd0);
        chk("rst_cnt", frame_cnt, 16'd0);
        rst = 1'b0;
        step(2);
        chk("idle_load", {15'd0, load}, 16'd0);

        // continuous run; enable falls at shift cycle 5 of the 4th frame
        ssr_enable = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            int p;
            step(1);
            p = c % 13;
            chk_frame("cont", c, (c <= 52) && (p == 1), (c <= 52) && (p >= 2) && (p <= 9),
                      (c <= 52) && (p == 10));
            if (c == 40) chk("cont_cnt3", frame_cnt, 16'd3);
            if (c == 45) ssr_enable = 1'b0;
        end
        chk("dis_cnt4", frame_cnt, 16'd4);

        // single flush from IDLE
        ssr_flush_req = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step(1);
            ssr_flush_req = 1'b0;
            chk_frame("flidle", c, c == 1, (c >= 2) && (c <= 9), c == 10);
        end
        chk("flidle_cnt5", frame_cnt, 16'd5);

        // flush at shift cycle 3 with enable high: gap cut to one cycle
        ssr_enable = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            chk_frame("flshift", c, (c == 1) || (c == 11),
                      ((c >= 2) && (c <= 9)) || ((c >= 12) && (c <= 19)),
                      (c == 10) || (c == 20));
            ssr_flush_req = (c == 4);
            if (c == 12) ssr_enable = 1'b0;
        end
        chk("flshift_cnt7", frame_cnt, 16'd7);

        // transfer-enable confirmation (frame_done at 10, 23, 36, 49, 62, 75)
        req        = 1'b1;
        echo       = 1'b1;
        ssr_enable = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            step(1);
            case (c)
                11, 23: chk($sformatf("conf_low_c%0d", c), {15'd0, confirmed}, 16'd0);
                24, 36: chk($sformatf("conf_high_c%0d", c), {15'd0, confirmed}, 16'd1);
                37, 62: chk($sformatf("conf_drop_c%0d", c), {15'd0, confirmed}, 16'd0);
                63, 65: chk($sformatf("conf_again_c%0d", c), {15'd0, confirmed}, 16'd1);
                66:     chk("conf_reqfall", {15'd0, confirmed}, 16'd0);
                default: ;
            endcase
            if (c == 25) echo = 1'b0;
            if (c == 38) echo = 1'b1;
            if (c == 65) req = 1'b0;
            if (c == 66) ssr_enable = 1'b0;
        end
        step(20);
        chk("conf_cnt13", frame_cnt, 16'd13);
        chk("conf_idle_load", {15'd0, load}, 16'd0);
        chk("conf_idle_conf", {15'd0, confirmed}, 16'd0);

        // reset while shifting, with the handshake confirmed beforehand
        req        = 1'b1;
        echo       = 1'b1;
        ssr_enable = 1'b1;
        step(30);
        chk("pre_rst_conf", {15'd0, confirmed}, 16'd1);
        chk("pre_rst_shift", {15'd0, shift_en}, 16'd1);
        chk("pre_rst_cnt", frame_cnt, 16'd15);
        step(1);
        rst = 1'b1;
        step(1);
        chk("midrst_load", {15'd0, load}, 16'd0);
        chk("midrst_shift", {15'd0, shift_en}, 16'd0);
        chk("midrst_done", {15'd0, frame_done}, 16'd0);
        chk("midrst_conf", {15'd0, confirmed}, 16'd0);
        chk("midrst_cnt", frame_cnt, 16'd0);
        ssr_enable = 1'b0;
        rst        = 1'b0;
        step(3);
        chk("post_rst_load", {15'd0, load}, 16'd0);
        chk("post_rst_shift", {15'd0, shift_en}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_c3aibadapt_avmm_ssr_sched
